// File: rtl/reg_wb_pkg.sv
// Shared parameters, requester indices and request payload for the writeback arbiter.
package reg_wb_pkg;

  localparam int unsigned NREQ = 5;
  localparam int unsigned NWP  = 2;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned PW   = $clog2(NREQ);

  localparam int unsigned REQ_MOV  = 0;
  localparam int unsigned REQ_ALU  = 1;
  localparam int unsigned REQ_JUMP = 2;
  localparam int unsigned REQ_FPU  = 3;
  localparam int unsigned REQ_IMM  = 4;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_rr_pick.sv
// Find-first set bit of an eligibility mask, scanning upward from a rotating pointer.
module rr_pick
  import reg_wb_pkg::*;
(
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic            found,
  output logic [PW-1:0]   idx
);

  // Scan ptr, ptr+1, ... mod NREQ and keep the first eligible index
  always_comb begin
    int unsigned j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && mask[PW'(j)]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant of up to NWP non-conflicting
// writes per cycle into a registered write-port stage, plus pending-write mask.
// Optional feature macro: REG_WB_ZERO_EN (address 0 hard-wired zero, bypassed).
module reg_wb_arbiter
  import reg_wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NWP-1:0]       wp_en,
  output logic [NWP*AW-1:0]    wp_addr,
  output logic [NWP*DW-1:0]    wp_data,
  output logic [NREG-1:0]      pend_mask
);

  wb_req_t              req [NREQ];
  logic [NREQ-1:0]      zero_hit;
  logic [NREQ-1:0]      base_elig;
  logic [NREQ-1:0]      granted;
  logic [NWP-1:0]       pick_found;
  logic [NWP*PW-1:0]    pick_idx;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NWP-1:0]       wp_en_q, wp_en_d;
  logic [NWP*AW-1:0]    wp_addr_q, wp_addr_d;
  logic [NWP*DW-1:0]    wp_data_q, wp_data_d;

  // Unpack the flat request buses and flag address-0 bypass requests
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      req[i].valid = req_valid[i];
      req[i].addr  = req_addr[i*AW +: AW];
      req[i].data  = req_data[i*DW +: DW];
`ifdef REG_WB_ZERO_EN
      zero_hit[i]  = req_valid[i] && (req_addr[i*AW +: AW] == '0);
`else
      zero_hit[i]  = 1'b0;
`endif
      base_elig[i] = req[i].valid && !zero_hit[i];
    end
  end

  // Pick chain: each stage drops the previous winner and everything sharing its address
  for (genvar p = 0; p < NWP; p++) begin : g_pick
    logic [NREQ-1:0] mask;
    logic            found;
    logic [PW-1:0]   idx;

    if (p == 0) begin : g_head
      assign mask = base_elig;
    end else begin : g_tail
      // Remove the earlier grant and its same-address competitors
      always_comb begin
        mask = g_pick[p-1].mask;
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (g_pick[p-1].found && (req[i].addr == req[g_pick[p-1].idx].addr)) begin
            mask[i] = 1'b0;
          end
        end
      end
    end

    rr_pick u_pick (
      .mask  (mask),
      .ptr   (rr_ptr_q),
      .found (found),
      .idx   (idx)
    );

    assign pick_found[p]          = found;
    assign pick_idx[p*PW +: PW]   = idx;
  end

  // Combinational handshake: arbitration winners plus zero-register bypass, gated by reset
  always_comb begin
    granted = '0;
    for (int unsigned p = 0; p < NWP; p++) begin
      if (pick_found[p]) granted[pick_idx[p*PW +: PW]] = 1'b1;
    end
    req_ready = reset ? '0 : (granted | zero_hit);
  end

  // Next output stage and round-robin pointer from this cycle's grants
  always_comb begin
    logic [PW-1:0] sel;
    sel       = '0;
    wp_en_d   = '0;
    wp_addr_d = wp_addr_q;
    wp_data_d = wp_data_q;
    rr_ptr_d  = rr_ptr_q;
    for (int unsigned p = 0; p < NWP; p++) begin
      sel = pick_idx[p*PW +: PW];
      if (pick_found[p]) begin
        wp_en_d[p]            = 1'b1;
        wp_addr_d[p*AW +: AW] = req[sel].addr;
        wp_data_d[p*DW +: DW] = req[sel].data;
        rr_ptr_d              = (sel == PW'(REQ_IMM)) ? PW'(REQ_MOV) : sel + PW'(1);
      end
    end
  end

  // State registers; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      wp_en_q   <= '0;
      wp_addr_q <= '0;
      wp_data_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wp_en_q   <= wp_en_d;
      wp_addr_q <= wp_addr_d;
      wp_data_q <= wp_data_d;
    end
  end

  // Pending-write mask decoded from the output stage only
  always_comb begin
    pend_mask = '0;
    for (int unsigned p = 0; p < NWP; p++) begin
      if (wp_en_q[p]) pend_mask[wp_addr_q[p*AW +: AW]] = 1'b1;
    end
  end

  assign wp_en   = wp_en_q;
  assign wp_addr = wp_addr_q;
  assign wp_data = wp_data_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: scan-order reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_reg_wb_arbiter;
  import reg_wb_pkg::*;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NWP-1:0]       wp_en;
  logic [NWP*AW-1:0]    wp_addr;
  logic [NWP*DW-1:0]    wp_data;
  logic [NREG-1:0]      pend_mask;

  int nchk = 0;
  int nfail = 0;

  // Reference model state
  int                 m_rr = 0;
  logic [NWP-1:0]     m_en = '0;
  logic [NWP*AW-1:0]  m_addr = '0;
  logic [NWP*DW-1:0]  m_data = '0;

  reg_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wp_en     (wp_en),
    .wp_addr   (wp_addr),
    .wp_data   (wp_data),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Greedy walk in scan order: take a valid requester unless ports are full or its
  // address is already being written this cycle.
  function automatic void model_arb(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                                    input int rr, output int ng,
                                    output logic [NWP*8-1:0] gi, output logic [NREQ-1:0] rdy);
    int gl [NWP];
    ng  = 0;
    gi  = '0;
    rdy = '0;
    for (int q = 0; q < NWP; q++) gl[q] = 0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      logic [AW-1:0] ai;
      bit clash;
      i  = int'((rr + k) % NREQ);
      ai = a[i*AW +: AW];
      clash = 1'b0;
      if (v[i]) begin
`ifdef REG_WB_ZERO_EN
        if (ai == '0) begin
          rdy[i] = 1'b1;
          continue;
        end
`endif
        if (ng < NWP) begin
          for (int q = 0; q < ng; q++) if (a[gl[q]*AW +: AW] == ai) clash = 1'b1;
          if (!clash) begin
            gl[ng] = i;
            gi[ng*8 +: 8] = 8'(i);
            ng++;
            rdy[i] = 1'b1;
          end
        end
      end
    end
  endfunction

  // Advance the model on each clock edge from the inputs present before the edge
  always @(posedge clk) begin : model_upd
    int ng;
    int g;
    logic [NWP*8-1:0] gi;
    logic [NREQ-1:0]  rdy;
    if (reset) begin
      m_rr   = 0;
      m_en   = '0;
      m_addr = '0;
      m_data = '0;
    end else begin
      model_arb(req_valid, req_addr, m_rr, ng, gi, rdy);
      m_en = '0;
      for (int p = 0; p < ng; p++) begin
        g = int'(gi[p*8 +: 8]);
        m_en[p] = 1'b1;
        m_addr[p*AW +: AW] = req_addr[g*AW +: AW];
        m_data[p*DW +: DW] = req_data[g*DW +: DW];
        m_rr = (g + 1) % NREQ;
      end
    end
  end

  // Compare every DUT output against the model mid-cycle
  always @(negedge clk) begin : compare
    int ng;
    logic [NWP*8-1:0] gi;
    logic [NREQ-1:0]  rdy;
    logic [NREG-1:0]  pm;
    model_arb(req_valid, req_addr, m_rr, ng, gi, rdy);
    if (reset) rdy = '0;
    pm = '0;
    for (int p = 0; p < NWP; p++) if (m_en[p]) pm[m_addr[p*AW +: AW]] = 1'b1;
    chk("model_ready", req_ready, rdy);
    chk("model_wp_en", wp_en, m_en);
    chk("model_wp_addr", wp_addr, m_addr);
    chk("model_wp_data", wp_data, m_data);
    chk("model_pend", pend_mask, pm);
  end

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  logic [NREQ-1:0] fair_exp [5];
  int              gcnt [NREQ];
  logic [NREQ-1:0] fired;

  initial begin
    fair_exp[0] = 5'b00011;
    fair_exp[1] = 5'b01100;
    fair_exp[2] = 5'b10001;
    fair_exp[3] = 5'b00110;
    fair_exp[4] = 5'b11000;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;

    // Reset with everyone requesting distinct addresses 1..5
    reset     = 1'b1;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = $urandom;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_wp_en", wp_en, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_wp_addr", wp_addr, 0);
    reset = 1'b0;

    // Fairness: continuous requests rotate through pairs
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("fair_ready", req_ready, fair_exp[k]);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gcnt[i]++;
      tick();
      if (k == 0) begin
        chk("fair_first_en", wp_en, 2'b11);
        chk("fair_first_addr", wp_addr, {5'd2, 5'd1});
      end
    end
    chk("fair_last_addr", wp_addr, {5'd5, 5'd4});
    for (int i = 0; i < NREQ; i++) chk("fair_count", 64'(gcnt[i]), 2);

    // Idle cycle, pointer back at 0
    req_valid = '0;
    tick();

    // Same-address conflict between alu and fpu
    req_valid = '0;
    req_valid[REQ_ALU] = 1'b1;
    req_valid[REQ_FPU] = 1'b1;
    req_addr[REQ_ALU*AW +: AW] = 5'd7;
    req_addr[REQ_FPU*AW +: AW] = 5'd7;
    req_data[REQ_ALU*DW +: DW] = 32'hAAAA_0001;
    req_data[REQ_FPU*DW +: DW] = 32'hBBBB_0002;
    #1;
    chk("conf_ready0", req_ready, 5'b00010);
    tick();
    chk("conf_en0", wp_en, 2'b01);
    chk("conf_addr0", wp_addr[AW-1:0], 5'd7);
    chk("conf_data0", wp_data[DW-1:0], 32'hAAAA_0001);
    req_valid[REQ_ALU] = 1'b0;
    #1;
    chk("conf_ready1", req_ready, 5'b01000);
    tick();
    chk("conf_data1", wp_data[DW-1:0], 32'hBBBB_0002);
    chk("conf_en1", wp_en, 2'b01);

    // Latency and pending mask for a single mov write
    req_valid = 5'b00001;
    req_addr[REQ_MOV*AW +: AW] = 5'd9;
    req_data[REQ_MOV*DW +: DW] = 32'h0000_1234;
    #1;
    chk("lat_ready", req_ready, 5'b00001);
    tick();
    chk("lat_en", wp_en, 2'b01);
    chk("lat_addr", wp_addr[AW-1:0], 5'd9);
    chk("lat_data", wp_data[DW-1:0], 32'h0000_1234);
    chk("lat_pend", pend_mask, 32'h0000_0200);
    req_valid = '0;
    tick();
    chk("lat_en_off", wp_en, 2'b00);
    chk("lat_pend_off", pend_mask, 0);

    // Reset arriving at the edge that would have captured a grant
    req_valid = 5'b00001;
    req_data[REQ_MOV*DW +: DW] = 32'h5555_5555;
    #1;
    chk("rmid_ready", req_ready, 5'b00001);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rmid_en", wp_en, 2'b00);
    chk("rmid_pend", pend_mask, 0);
    reset     = 1'b0;
    req_valid = '0;
    tick();
    chk("rmid_en_after", wp_en, 2'b00);

    // Zero-register write alongside two ordinary writes
    req_valid = 5'b10110;
    req_addr[REQ_IMM*AW +: AW]  = 5'd0;
    req_addr[REQ_ALU*AW +: AW]  = 5'd3;
    req_addr[REQ_JUMP*AW +: AW] = 5'd4;
    #1;
`ifdef REG_WB_ZERO_EN
    chk("zero_ready", req_ready, 5'b10110);
`else
    chk("zero_ready", req_ready, 5'b00110);
`endif
    tick();
    chk("zero_en", wp_en, 2'b11);
    chk("zero_addr", wp_addr, {5'd4, 5'd3});
    chk("zero_pend", pend_mask, 32'h0000_0018);
    req_valid = '0;
    tick();

    // Randomized traffic with narrow addresses to force conflicts
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fired = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || fired[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            req_valid[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            req_data[i*DW +: DW] = $urandom;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      reset = ($urandom_range(0, 99) == 0);
    end

    reset     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
